// File: rtl/cassette_play_tx.sv
// rtl/cassette_play_tx.sv - CoCo cassette FSK playback encoder; optional 0x55 leader under CAS_LEADER_EN
module cassette_play_tx #(
    parameter int HALF0      = 5966,
    parameter int HALF1      = 2983,
    parameter int LEADER_LEN = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_ena,
    input  logic       motor,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       cas_out,
    output logic       busy,
    output logic       underrun
);
    localparam int HMAX = (HALF0 > HALF1) ? HALF0 : HALF1;
    localparam int CW   = $clog2(HMAX);
    localparam logic [CW-1:0] RELOAD0 = CW'(HALF0 - 1);
    localparam logic [CW-1:0] RELOAD1 = CW'(HALF1 - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HI   = 2'd1;
    localparam logic [1:0] ST_LO   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [7:0]    hold_q;
    logic          hold_full_q, hold_full_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d, next_idx;
    logic [CW-1:0] half_q, half_d;
    logic          cas_q, cas_d;
    logic          underrun_q, underrun_d;
    logic          tick, accept, consume, load;
    logic          have_byte, lead_act, load_block;
    logic [7:0]    next_byte;

    function automatic logic [CW-1:0] reload(input logic b);
        return b ? RELOAD1 : RELOAD0;
    endfunction

    assign tick     = clk_ena & motor;
    assign accept   = data_valid & ~hold_full_q;
    assign next_idx = bit_idx_q + 3'd1;

`ifdef CAS_LEADER_EN
    localparam int LW = $clog2(LEADER_LEN + 1);
    logic          motor_q;
    logic [LW-1:0] lead_q, lead_d;
    logic          lead_start;

    // A motor start seen in IDLE arms the leader and blocks loading the held byte that clk.
    assign lead_start = motor & ~motor_q & (state_q == ST_IDLE);
    assign lead_act   = (lead_q != '0);
    assign have_byte  = lead_act | hold_full_q;
    assign next_byte  = lead_act ? 8'h55 : hold_q;
    assign load_block = lead_start;

    always_comb begin
        lead_d = lead_q;
        if (lead_start)
            lead_d = LW'(LEADER_LEN);
        else if (load && lead_act)
            lead_d = lead_q - LW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            motor_q <= 1'b0;
            lead_q  <= '0;
        end else begin
            motor_q <= motor;
            lead_q  <= lead_d;
        end
    end
`else
    logic unused_leader;
    assign unused_leader = (LEADER_LEN > 0);
    assign lead_act      = 1'b0;
    assign have_byte     = hold_full_q;
    assign next_byte     = hold_q;
    assign load_block    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        half_d     = half_q;
        cas_d      = cas_q;
        underrun_d = 1'b0;
        load       = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    cas_d = 1'b0;
                    if (have_byte && !load_block)
                        load = 1'b1;
                end
                ST_HI: begin
                    if (half_q == '0) begin
                        cas_d   = 1'b0;
                        half_d  = reload(shift_q[bit_idx_q]);
                        state_d = ST_LO;
                    end else begin
                        half_d = half_q - CW'(1);
                    end
                end
                ST_LO: begin
                    if (half_q != '0) begin
                        half_d = half_q - CW'(1);
                    end else if (bit_idx_q != 3'd7) begin
                        bit_idx_d = next_idx;
                        half_d    = reload(shift_q[next_idx]);
                        cas_d     = 1'b1;
                        state_d   = ST_HI;
                    end else if (have_byte) begin
                        load = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                        cas_d      = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // Byte load is shared by IDLE start and seamless end-of-byte hand-off.
            if (load) begin
                shift_d   = next_byte;
                bit_idx_d = 3'd0;
                half_d    = reload(next_byte[0]);
                cas_d     = 1'b1;
                state_d   = ST_HI;
            end
        end
    end

    assign consume     = load & ~lead_act;
    assign hold_full_d = accept | (hold_full_q & ~consume);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            shift_q     <= 8'h00;
            bit_idx_q   <= 3'd0;
            half_q      <= '0;
            cas_q       <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            half_q      <= half_d;
            cas_q       <= cas_d;
            underrun_q  <= underrun_d;
            if (accept)
                hold_q <= data_in;
        end
    end

    assign data_ready = ~hold_full_q;
    assign cas_out    = cas_q;
    assign busy       = (state_q != ST_IDLE);
    assign underrun   = underrun_q;
endmodule

// File: tb/tb_cassette_play_tx.sv
// tb/tb_cassette_play_tx.sv - scoreboard bench for cassette_play_tx (HALF0=6, HALF1=3, clk_ena every 4th clk)
module tb_cassette_play_tx;
    localparam int H0 = 6;
    localparam int H1 = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clk_ena = 1'b0;
    logic       motor = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready, cas_out, busy, underrun;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int hi_cnt = 0, lo_cnt = 0;
    int urun_cnt = 0, urun_off_cnt = 0, busy_fall = 0;
    logic busy_prev = 1'b0;

    cassette_play_tx #(.HALF0(H0), .HALF1(H1), .LEADER_LEN(2)) dut (
        .clk(clk), .reset(reset), .clk_ena(clk_ena), .motor(motor),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .cas_out(cas_out), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            k++;
            clk_ena = (k % 4 == 0);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic emit_cycle();
        int e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL cycle: got hi=%0d lo=%0d, expected no cycle", hi_cnt, lo_cnt);
        end else begin
            e = exp_q.pop_front();
            if (hi_cnt != e || lo_cnt != e) begin
                n_fail++;
                $display("FAIL cycle: got hi=%0d lo=%0d, expected hi=%0d lo=%0d", hi_cnt, lo_cnt, e, e);
            end
        end
        hi_cnt = 0;
        lo_cnt = 0;
    endtask

    // Monitor: measures each FSK cycle in ticks and scores it against the expected queue.
    always @(negedge clk) begin
        if (!reset) begin
            hi_cnt    = 0;
            lo_cnt    = 0;
            busy_prev = 1'b0;
        end else begin
            if (underrun) begin
                urun_cnt++;
                if (!motor) urun_off_cnt++;
            end
            if (busy_prev && !busy) busy_fall++;
            busy_prev = busy;
            if (!busy) begin
                if (hi_cnt != 0 || lo_cnt != 0) emit_cycle();
            end else if (clk_ena && motor) begin
                if (cas_out) begin
                    if (lo_cnt != 0) emit_cycle();
                    hi_cnt++;
                end else begin
                    lo_cnt++;
                end
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i] ? H1 : H0);
    endtask

    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        while (!data_ready && w < 3000) begin
            clks(1);
            w++;
        end
        if (w >= 3000) check("ready_timeout", 0, 1);
        data_in    = b;
        data_valid = 1'b1;
        push_byte(b);
        clks(1);
        data_valid = 1'b0;
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || busy) && w < 4000) begin
            clks(1);
            w++;
        end
        check("drain", exp_q.size(), 0);
        clks(3);
    endtask

    task automatic clr();
        urun_cnt     = 0;
        urun_off_cnt = 0;
        busy_fall    = 0;
    endtask

    initial begin
        int changes, w;
        logic prev;

        clks(3);
        check("rst_cas", cas_out, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ready", data_ready, 1);
        reset = 1'b1;
        clks(2);

`ifdef CAS_LEADER_EN
        push_byte(8'h55);
        push_byte(8'h55);
        send(8'h3C);
        clks(8);
        motor = 1'b1;
        wait_done();
        check("leader_underrun", urun_cnt, 1);
        check("leader_busy_fall", busy_fall, 1);
`else
        motor = 1'b1;
`endif

        // 0xFF then 0x00 then 0x01, each followed by an underrun
        clr();
        send(8'hFF);
        wait_done();
        check("ff_underrun", urun_cnt, 1);
        check("ff_cas_idle", cas_out, 0);
        check("ff_busy_idle", busy, 0);
        send(8'h00);
        wait_done();
        send(8'h01);
        wait_done();
        check("t2_underrun", urun_cnt, 3);

        // back-to-back stream: seamless hand-off
        clr();
        send(8'hA5);
        send(8'h3C);
        check("stream_ready_drop", data_ready, 0);
        w = 0;
        while (!data_ready && w < 3000) begin
            clks(1);
            w++;
        end
        check("stream_handoff_busy", busy, 1);
        check("stream_no_gap", busy_fall, 0);
        check("stream_no_early_underrun", urun_cnt, 0);
        wait_done();
        check("stream_underrun", urun_cnt, 1);
        check("stream_busy_fall", busy_fall, 1);

        // motor off mid-bit for 50 ticks
        clr();
        send(8'h00);
        clks(30);
        motor   = 1'b0;
        changes = 0;
        prev    = cas_out;
        for (int i = 0; i < 200; i++) begin
            clks(1);
            if (cas_out != prev) changes++;
            prev = cas_out;
        end
        check("motor_off_busy", busy, 1);
        check("motor_off_cas_frozen", changes, 0);
        motor = 1'b1;
        wait_done();
        check("motor_off_underrun", urun_off_cnt, 0);
        check("motor_underrun", urun_cnt, 1);

        // async reset mid-byte, then restart with 0x55
        clr();
        send(8'h00);
        clks(80);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("areset_cas", cas_out, 0);
        check("areset_busy", busy, 0);
        check("areset_ready", data_ready, 1);
        check("areset_underrun", underrun, 0);
        exp_q.delete();
        clks(3);
        reset = 1'b1;
`ifdef CAS_LEADER_EN
        push_byte(8'h55);
        push_byte(8'h55);
`endif
        send(8'h55);
        wait_done();
        check("areset_after_underrun", urun_cnt, 1);
        check("areset_after_busy_fall", busy_fall, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
